// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array: index width helper, weight type
// and the weight loader state encoding.
package systolic_pkg;

    localparam int SA_DEFAULT_N  = 16;
    localparam int SA_DEFAULT_DW = 8;

    // Width of a row index for an N-row array; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(SA_DEFAULT_N);

    typedef logic signed [7:0] weight_t;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOADED = 2'd2
    } loader_state_t;

endpackage

// File: rtl/weight_tile_buffer.sv
// N x N weight tile store: one row written per accepted beat, one row read
// combinationally for the drain path. Contents need no reset.
module weight_tile_buffer #(
    parameter int N  = 16,
    parameter int DW = 8,
    parameter int IW = 4
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [IW-1:0]     i_wr_row,
    input  logic [N*DW-1:0]   i_wr_data,
    input  logic [IW-1:0]     i_rd_row,
    output logic [N*DW-1:0]   o_rd_data
);

    logic [N*DW-1:0] r_mem [N];

    // Capture an incoming weight row at the fill position.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_row] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_row];

endmodule

// File: rtl/weight_loader.sv
// Tile-level weight stream transmitter for the north edge of the systolic
// array. Buffers a full N x N tile, then issues rows N-1 down to 0 so every
// PE latches its weight on the same edge. Holds a second tile until the
// activation sequencer reports the weight switch has propagated.
// Optional build macro: WL_TILE_CHECK_EN enables s_last framing checks.
module weight_loader
    import systolic_pkg::*;
#(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_IN        = 8
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 s_valid,
    output logic                                                 s_ready,
    input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0]        s_data,
    input  logic                                                 s_last,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]                      col_en,
    output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0]        w_data_out,
    output logic [SYSTOLIC_ARRAY_WIDTH*idx_width(SYSTOLIC_ARRAY_WIDTH)-1:0] w_index_out,
    output logic [SYSTOLIC_ARRAY_WIDTH-1:0]                      w_accept_out,
    output logic                                                 tile_loaded,
    input  logic                                                 switch_done,
    output logic                                                 busy,
    output logic                                                 err_last
);

    localparam int N  = SYSTOLIC_ARRAY_WIDTH;
    localparam int DW = DATA_WIDTH_IN;
    localparam int IW = idx_width(N);
    localparam int FW = $clog2(N + 1);

    loader_state_t     r_state;
    logic [FW-1:0]     r_fcnt;
    logic [IW-1:0]     r_dcnt;
    logic [N*DW-1:0]   r_data;
    logic [N*IW-1:0]   r_index;
    logic [N-1:0]      r_accept;

    logic              w_accept_beat;
    logic              w_full;
    logic              w_last_row;
    logic              w_issue;
    logic [IW-1:0]     w_next_dcnt;
    logic [IW-1:0]     w_rd_row;
    logic [N*DW-1:0]   w_rd_data;
    logic [N*DW-1:0]   w_data_nxt;
    logic [N*IW-1:0]   w_index_nxt;
    logic [N-1:0]      w_accept_nxt;

    assign w_full        = (r_fcnt == FW'(N));
    assign w_last_row    = (r_dcnt == IW'(N - 1));
    assign s_ready       = !w_full && (r_state == ST_FILL || r_state == ST_LOADED);
    assign w_accept_beat = s_valid && s_ready;

    // A row is issued on the edge that enters DRAIN and on every DRAIN edge
    // until row 0 is already on the outputs; r_dcnt tracks the row shown.
    assign w_issue = (r_state == ST_FILL   && w_full) ||
                     (r_state == ST_DRAIN  && !w_last_row) ||
                     (r_state == ST_LOADED && switch_done && w_full);

    assign w_next_dcnt = (r_state == ST_DRAIN) ? (r_dcnt + IW'(1)) : '0;
    assign w_rd_row    = IW'(N - 1) - w_next_dcnt;

    weight_tile_buffer #(
        .N  (N),
        .DW (DW),
        .IW (IW)
    ) u_buffer (
        .clk       (clk),
        .i_wr_en   (w_accept_beat),
        .i_wr_row  (r_fcnt[IW-1:0]),
        .i_wr_data (s_data),
        .i_rd_row  (w_rd_row),
        .o_rd_data (w_rd_data)
    );

    // Sequence fill, drain and hold phases and keep the fill/drain counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_fcnt  <= '0;
            r_dcnt  <= '0;
        end else begin
            if (w_accept_beat) begin
                r_fcnt <= r_fcnt + FW'(1);
            end
            case (r_state)
                ST_FILL: begin
                    if (w_full) begin
                        r_state <= ST_DRAIN;
                        r_dcnt  <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_row) begin
                        r_state <= ST_LOADED;
                        r_fcnt  <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + IW'(1);
                    end
                end
                ST_LOADED: begin
                    if (switch_done) begin
                        if (w_full) begin
                            r_state <= ST_DRAIN;
                            r_dcnt  <= '0;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    // Build the next per-column weight/index/accept, zero on masked columns.
    always_comb begin
        w_data_nxt   = '0;
        w_index_nxt  = '0;
        w_accept_nxt = '0;
        if (w_issue) begin
            for (int c = 0; c < N; c++) begin
                if (col_en[c]) begin
                    w_data_nxt[c*DW +: DW]  = w_rd_data[c*DW +: DW];
                    w_index_nxt[c*IW +: IW] = w_rd_row;
                    w_accept_nxt[c]         = 1'b1;
                end
            end
        end
    end

    // Register the north-edge stream; idle cycles drive all zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_index  <= '0;
            r_accept <= '0;
        end else begin
            r_data   <= w_data_nxt;
            r_index  <= w_index_nxt;
            r_accept <= w_accept_nxt;
        end
    end

    assign w_data_out   = r_data;
    assign w_index_out  = r_index;
    assign w_accept_out = r_accept;
    assign tile_loaded  = (r_state == ST_LOADED);
    assign busy         = (r_state != ST_FILL) || (r_fcnt != '0);

`ifdef WL_TILE_CHECK_EN
    logic r_err_last;

    // Flag any beat whose s_last disagrees with its position in the tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_last <= 1'b0;
        end else if (w_accept_beat && (s_last != (r_fcnt == FW'(N - 1)))) begin
            r_err_last <= 1'b1;
        end
    end

    assign err_last = r_err_last;
`else
    logic w_unused_last;
    assign w_unused_last = s_last;
    assign err_last      = 1'b0;
`endif

endmodule

// File: doc/weight_loader.md
# weight_loader

Tile-level weight stream transmitter that drives the north edge of the systolic array. It accepts one N×N int8 weight tile as N row-beats over a ready/valid stream and buffers the whole tile. It then issues the rows to every column in descending row-index order, so that each PE's index-match logic latches its weight into the inactive register on the same cycle. It reports when the tile has landed, and it holds the next tile until the activation sequencer confirms that the weight switch has propagated.

## Interface
- SYSTOLIC_ARRAY_WIDTH, 16, array dimension N (rows = columns)
- DATA_WIDTH_IN, 8, weight width (signed int8)
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- s_valid  in  1  upstream row-beat valid
- s_ready  out  1  loader can accept a beat
- s_data  in  N*DATA_WIDTH_IN  one weight row; column c at [c*8+7:c*8]
- s_last  in  1  marks final beat of tile
- col_en  in  N  column enable mask (same mask as array column enables)
- w_data_out  out  N*DATA_WIDTH_IN  per-column weight to PE row 0 (pe_weight_in)
- w_index_out  out  N*$clog2(N)  per-column row index (pe_index_in)
- w_accept_out  out  N  per-column weight-stream valid (pe_accept_w_in)
- tile_loaded  out  1  level; all N×N weights resident in inactive registers
- switch_done  in  1  single-cycle pulse from sequencer: switch has reached every PE
- busy  out  1  state ≠ FILL or fill count ≠ 0
- err_last  out  1  sticky tile-framing error (only with WL_TILE_CHECK_EN)

## Operation
- Buffer: N×N×8-bit register array plus fill counter fcnt (0..N).
- A beat is accepted when s_valid and s_ready are both high. It is written to buffer row fcnt, and fcnt then increments.
- s_ready = (fcnt < N) and state ∈ {FILL, LOADED}.
- FSM:
  - FILL: when fcnt reaches N, go to DRAIN and clear the drain counter dcnt.
  - DRAIN: each cycle, register buffer row r = N−1−dcnt onto the outputs, with w_index_out = r for every column and w_accept_out = col_en. After dcnt = N−1, go to LOADED and clear fcnt to 0.
  - LOADED: tile_loaded = 1. Refilling is permitted. On switch_done: go to DRAIN if fcnt = N, otherwise go to FILL.
- switch_done is ignored in FILL and DRAIN.
- Outside a DRAIN-issue cycle, w_data_out, w_index_out and w_accept_out are all 0. This matches the PE stop state.
- A disabled column (col_en[c] = 0, sampled per issue cycle) drives zero data, zero index and zero accept.
- No arithmetic. Indices are unsigned, $clog2(N) bits wide. Weight bits pass through unmodified.

## Timing
- Reset: s_ready = 1 (FILL, fcnt = 0); all w_* outputs 0; tile_loaded = 0; busy = 0; err_last = 0. The buffer contents are don't-care.
- Accept to first issue: the beat that makes fcnt = N is accepted at edge E. Row N−1 appears on the outputs in cycle E+1.
- Drain takes N cycles: row N−1 at E+1, down to row 0 at E+N.
- Landing: the row issued with index r reaches PE row r after r register hops. All rows are therefore latched at the same edge, the end of cycle E+N.
- tile_loaded rises in cycle E+N+1 and falls the cycle after switch_done is sampled.
- Back-to-back tiles: the second tile can be fully buffered during LOADED. Its DRAIN starts the cycle after switch_done.
- Reset mid-DRAIN or mid-FILL: outputs are zero on the next cycle and the partial tile is discarded. The array may hold a partially overwritten inactive tile; software must reload.

## Configuration
- WL_TILE_CHECK_EN defined: s_last is checked on every accepted beat. Any mismatch (s_last = 1 when fcnt ≠ N−1, or s_last = 0 when fcnt = N−1) sets err_last, which holds until rst. The beat is still accepted and data flow is unchanged.
- WL_TILE_CHECK_EN undefined: s_last is ignored and err_last is tied to 0.

## Structure
- Shared package (systolic_pkg) holds:
  - IDX_W = $clog2(N)
  - the weight_t (signed int8) typedef
  - the loader state enum {FILL, DRAIN, LOADED}
- One sub-module: weight_tile_buffer. It holds the N×N register array with a write row port (fcnt) and a read row port (N−1−dcnt). The FSM, counters and output registers stay in weight_loader.

## Test plan
Directed scenarios, all with N = 4 and col_en = 4'b1111 unless stated.
- Single tile: rows 0..3 are loaded with values 10r+c. Outputs then show index 3,2,1,0 on consecutive cycles with data 30..33, 20..23, ... tile_loaded rises 5 cycles after the last accept. A 4×4 PE model holds inactive[r][c] = 10r+c.
- Backpressure: s_valid stays high through drain. s_ready is 0 during DRAIN and 1 in LOADED. A second tile is fully accepted and no drain starts until switch_done; DRAIN begins the cycle after the pulse.
- Column mask: col_en = 4'b0101 gives w_accept_out = 0101 and zero data/index on columns 1 and 3 in every issue cycle.
- Spurious switch: a switch_done pulse during FILL (fcnt = 2) and during DRAIN (dcnt = 1) has no effect. The sequence completes normally.
- Reset mid-drain: rst is asserted at dcnt = 2. Next cycle all outputs are 0, s_ready = 1, busy = 0. A fresh tile then loads correctly.
- Framing (WL_TILE_CHECK_EN): s_last on beat 1 sets err_last, which stays at 1. Without the macro, err_last stays 0 and the tile loads normally.
